// File: rtl/rps_round_ctrl.sv
// Rock-paper-scissors match controller: collects one move per player per round, judges,
// keeps round-win scores and ends the match on a target score or when the match timer runs out.
module rps_round_ctrl #(
  parameter int unsigned WIN_SCORE = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       p1_valid,
  input  logic       p2_valid,
  input  logic [1:0] p1_move,
  input  logic [1:0] p2_move,
  input  logic       timer_expired,
  output logic       timer_go,
  output logic       round_done,
  output logic [1:0] round_result,
  output logic [2:0] score1,
  output logic [2:0] score2,
  output logic       match_over,
  output logic [1:0] winner
);

  localparam logic [2:0] WinScore = 3'(WIN_SCORE);
  localparam logic [1:0] Rock     = 2'b00;
  localparam logic [1:0] Paper    = 2'b01;
  localparam logic [1:0] Scissors = 2'b10;
  localparam logic [1:0] Illegal  = 2'b11;

  typedef enum logic [2:0] {StIdle, StCollect, StJudge, StReport, StOver} state_e;

  state_e     state_q, state_d;
  logic [1:0] move1_q, move1_d, move2_q, move2_d;
  logic       lock1_q, lock1_d, lock2_q, lock2_d;
  logic       armed_q, armed_d;
  logic [1:0] result_q, result_d, winner_q, winner_d;
  logic [2:0] score1_q, score1_d, score2_q, score2_d;
  logic       time_up, p1_beats, p2_beats;

  // The timer level is only meaningful once it has been seen running (low) at least once.
  assign time_up = armed_q & timer_expired;

  assign p1_beats = (move1_q == Rock     && move2_q == Scissors) ||
                    (move1_q == Scissors && move2_q == Paper)    ||
                    (move1_q == Paper    && move2_q == Rock);
  assign p2_beats = (move2_q == Rock     && move1_q == Scissors) ||
                    (move2_q == Scissors && move1_q == Paper)    ||
                    (move2_q == Paper    && move1_q == Rock);

  always_comb begin
    state_d    = state_q;
    move1_d    = move1_q;
    move2_d    = move2_q;
    lock1_d    = lock1_q;
    lock2_d    = lock2_q;
    result_d   = result_q;
    winner_d   = winner_q;
    score1_d   = score1_q;
    score2_d   = score2_q;
    timer_go   = (state_q != StIdle);
    round_done = 1'b0;
    match_over = 1'b0;
    armed_d    = armed_q | ((state_q != StIdle) & ~timer_expired);

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StCollect;
          score1_d = '0;
          score2_d = '0;
          lock1_d  = 1'b0;
          lock2_d  = 1'b0;
          armed_d  = 1'b0;
        end
      end
      StCollect: begin
        if (time_up) begin
          state_d = StOver;
        end else if (lock1_q && lock2_q) begin
          state_d = StJudge;
        end else begin
          if (!lock1_q && p1_valid && p1_move != Illegal) begin
            move1_d = p1_move;
            lock1_d = 1'b1;
          end
          if (!lock2_q && p2_valid && p2_move != Illegal) begin
            move2_d = p2_move;
            lock2_d = 1'b1;
          end
        end
      end
      StJudge: begin
        state_d = StReport;
        if (p1_beats) begin
          result_d = 2'b01;
          if (score1_q < WinScore) score1_d = score1_q + 3'd1;
        end else if (p2_beats) begin
          result_d = 2'b10;
          if (score2_q < WinScore) score2_d = score2_q + 3'd1;
        end else begin
          result_d = 2'b00;
        end
      end
      StReport: begin
        round_done = 1'b1;
        lock1_d    = 1'b0;
        lock2_d    = 1'b0;
        if (score1_q == WinScore || score2_q == WinScore || time_up) begin
          state_d = StOver;
        end else begin
          state_d = StCollect;
        end
      end
      StOver: begin
        match_over = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // Winner is frozen from the scores at the moment the match ends.
    if (state_d == StOver && state_q != StOver) begin
      if (score1_q > score2_q)      winner_d = 2'b01;
      else if (score2_q > score1_q) winner_d = 2'b10;
      else                          winner_d = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      move1_q  <= '0;
      move2_q  <= '0;
      lock1_q  <= 1'b0;
      lock2_q  <= 1'b0;
      armed_q  <= 1'b0;
      result_q <= '0;
      winner_q <= '0;
      score1_q <= '0;
      score2_q <= '0;
    end else begin
      state_q  <= state_d;
      move1_q  <= move1_d;
      move2_q  <= move2_d;
      lock1_q  <= lock1_d;
      lock2_q  <= lock2_d;
      armed_q  <= armed_d;
      result_q <= result_d;
      winner_q <= winner_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
    end
  end

  assign round_result = result_q;
  assign score1       = score1_q;
  assign score2       = score2_q;
  assign winner       = winner_q;

endmodule

// File: tb/tb_rps_round_ctrl.sv
// Bench for rps_round_ctrl: a table of cycle vectors, directed corner sequences and a random run,
// all also compared every cycle against a round/score model of the game rules.
module tb_rps_round_ctrl;

  localparam int W = 3;
  localparam int PIdle = 0, PCollect = 1, PJudge = 2, PReport = 3, POver = 4;

  logic       clk = 1'b0;
  logic       reset, start, p1_valid, p2_valid, timer_expired;
  logic [1:0] p1_move, p2_move;
  logic       timer_go, round_done, match_over;
  logic [1:0] round_result, winner;
  logic [2:0] score1, score2;

  int vectors = 0;
  int miscompares = 0;

  // Model of the match: phase, locked moves, arming flag, scores and registered outputs.
  int m_ph, m_mv1, m_mv2, m_s1, m_s2, m_rr, m_w;
  bit m_l1, m_l2, m_armed;

  rps_round_ctrl #(.WIN_SCORE(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .p1_valid     (p1_valid),
    .p2_valid     (p2_valid),
    .p1_move      (p1_move),
    .p2_move      (p2_move),
    .timer_expired(timer_expired),
    .timer_go     (timer_go),
    .round_done   (round_done),
    .round_result (round_result),
    .score1       (score1),
    .score2       (score2),
    .match_over   (match_over),
    .winner       (winner)
  );

  always #5 clk = ~clk;

  // Packed observation: {timer_go, round_done, round_result, score1, score2, match_over, winner}
  logic [12:0] dut_vec;
  assign dut_vec = {timer_go, round_done, round_result, score1, score2, match_over, winner};

  function automatic logic [12:0] model_vec();
    logic [12:0] v;
    v = {m_ph != PIdle, m_ph == PReport, 2'(m_rr), 3'(m_s1), 3'(m_s2), m_ph == POver, 2'(m_w)};
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic end_match();
    m_ph = POver;
    m_w  = (m_s1 > m_s2) ? 1 : (m_s2 > m_s1) ? 2 : 0;
  endtask

  task automatic model_step();
    bit tu;
    int d;
    if (reset) begin
      m_ph = PIdle; m_s1 = 0; m_s2 = 0; m_rr = 0; m_w = 0;
      m_l1 = 0; m_l2 = 0; m_armed = 0; m_mv1 = 0; m_mv2 = 0;
      return;
    end
    tu = m_armed && timer_expired;
    if (m_ph != PIdle && !timer_expired) m_armed = 1;
    case (m_ph)
      PIdle: if (start) begin
        m_ph = PCollect; m_s1 = 0; m_s2 = 0; m_l1 = 0; m_l2 = 0; m_armed = 0;
      end
      PCollect: begin
        if (tu) end_match();
        else if (m_l1 && m_l2) m_ph = PJudge;
        else begin
          if (!m_l1 && p1_valid && p1_move != 2'd3) begin m_mv1 = int'(p1_move); m_l1 = 1; end
          if (!m_l2 && p2_valid && p2_move != 2'd3) begin m_mv2 = int'(p2_move); m_l2 = 1; end
        end
      end
      PJudge: begin
        // Each move beats the one numerically just below it, modulo 3.
        d = (m_mv1 - m_mv2 + 3) % 3;
        if (d == 1)      begin m_rr = 1; if (m_s1 < W) m_s1++; end
        else if (d == 2) begin m_rr = 2; if (m_s2 < W) m_s2++; end
        else m_rr = 0;
        m_ph = PReport;
      end
      PReport: begin
        m_l1 = 0; m_l2 = 0;
        if (m_s1 == W || m_s2 == W || tu) end_match();
        else m_ph = PCollect;
      end
      default: ;
    endcase
  endtask

  task automatic cyc(input bit rst_v, input bit st_v, input bit v1_v, input bit [1:0] m1_v,
                     input bit v2_v, input bit [1:0] m2_v, input bit te_v);
    reset = rst_v; start = st_v; p1_valid = v1_v; p1_move = m1_v;
    p2_valid = v2_v; p2_move = m2_v; timer_expired = te_v;
    @(posedge clk);
    model_step();
    #1;
    check("model", 16'(dut_vec), 16'(model_vec()));
  endtask

  task automatic idle(input bit te_v);
    cyc(0, 0, 0, 2'd0, 0, 2'd0, te_v);
  endtask

  typedef struct {
    bit rst, st, v1; bit [1:0] m1; bit v2; bit [1:0] m2; bit te;
    logic [12:0] exp;
  } vec_t;

  function automatic vec_t mk(bit rst, bit st, bit v1, bit [1:0] m1, bit v2, bit [1:0] m2,
                              bit te, bit tg, bit rd, bit [1:0] rr, bit [2:0] s1, bit [2:0] s2,
                              bit mo, bit [1:0] w);
    vec_t r;
    r.rst = rst; r.st = st; r.v1 = v1; r.m1 = m1; r.v2 = v2; r.m2 = m2; r.te = te;
    r.exp = {tg, rd, rr, s1, s2, mo, w};
    return r;
  endfunction

  vec_t tbl[16];
  bit   te_lvl;

  initial begin
    reset = 1; start = 0; p1_valid = 0; p2_valid = 0;
    p1_move = 0; p2_move = 0; timer_expired = 1;

    // Three straight P1 wins (rock vs scissors), then start in OVER, then reset.
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 1, 0, 1, 2, 0,  1, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 1, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 1, 0, 0, 0);
    tbl[6]  = mk(0, 0, 1, 0, 1, 2, 0,  1, 0, 1, 1, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 1, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 2, 0, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 2, 0, 0, 0);
    tbl[10] = mk(0, 0, 1, 0, 1, 2, 0,  1, 0, 1, 2, 0, 0, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 2, 0, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 3, 0, 0, 0);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 3, 0, 1, 1);
    tbl[14] = mk(0, 1, 0, 0, 0, 0, 0,  1, 0, 1, 3, 0, 1, 1);
    tbl[15] = mk(1, 1, 1, 0, 1, 2, 0,  0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].rst, tbl[i].st, tbl[i].v1, tbl[i].m1, tbl[i].v2, tbl[i].m2, tbl[i].te);
      check($sformatf("table[%0d]", i), 16'(dut_vec), 16'(tbl[i].exp));
    end

    // Tie with an illegal move first, then a relock attempt that must be ignored.
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 3, 1, 1, 0);
    cyc(0, 0, 1, 1, 0, 0, 0);
    idle(0);
    idle(0);
    check("tie_round_done", 16'(round_done), 16'd1);
    check("tie_result", 16'(round_result), 16'd0);
    check("tie_scores", 16'({score1, score2}), 16'd0);
    idle(0);
    check("tie_back_collect", 16'({timer_go, round_done, match_over}), 16'b100);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 1, 2, 0);
    idle(0);
    idle(0);
    check("relock_result", 16'(round_result), 16'd1);
    check("relock_score1", 16'(score1), 16'd1);

    // Timeout in COLLECT at 1-1 with only P1 locked.
    cyc(1, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0, 1);
    idle(1);
    idle(1);
    check("unarmed_no_over", 16'(match_over), 16'd0);
    cyc(0, 0, 1, 0, 1, 2, 0);
    idle(0); idle(0); idle(0);
    cyc(0, 0, 1, 0, 1, 1, 0);
    idle(0); idle(0); idle(0);
    check("to_scores", 16'({score1, score2}), 16'({3'd1, 3'd1}));
    cyc(0, 0, 1, 0, 0, 0, 0);
    idle(1);
    check("to_over", 16'(match_over), 16'd1);
    check("to_no_round_done", 16'(round_done), 16'd0);
    check("to_winner_draw", 16'(winner), 16'd0);

    // Time-up during JUDGE is deferred until after REPORT.
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 1, 2, 0);
    idle(0);
    idle(1);
    check("judge_to_round_done", 16'(round_done), 16'd1);
    check("judge_to_score1", 16'(score1), 16'd1);
    idle(1);
    check("judge_to_over", 16'({match_over, winner}), 16'b101);
    cyc(0, 1, 0, 0, 0, 0, 1);
    check("over_ignores_start", 16'({timer_go, match_over}), 16'b11);

    // Reset while REPORT is showing.
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 2, 1, 1, 0);
    idle(0);
    idle(0);
    check("report_reached", 16'(round_done), 16'd1);
    cyc(1, 0, 1, 0, 1, 0, 0);
    check("reset_in_report", 16'(dut_vec), 16'd0);

    // Random play with a slowly toggling timer level.
    te_lvl = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) te_lvl = ~te_lvl;
      cyc((m_ph == POver) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 299) == 0),
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
          $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
          te_lvl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rps_round_ctrl.md
RPS_ROUND_CTRL -- requirements
Module: rps_round_ctrl

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 3 (range 1-7): round wins needed to take the match.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  single-cycle match start request.
REQ-005 SHALL have ports p1_valid / p2_valid  input  1  player move strobe.
REQ-006 SHALL have ports p1_move / p2_move  input  2  move code: 00 rock, 01 paper, 10 scissors, 11 illegal.
REQ-007 SHALL have port timer_expired  input  1  match-timer level, high when the timer is idle or done.
REQ-008 SHALL have port timer_go  output  1  level that starts the match timer.
REQ-009 SHALL have port round_done  output  1  one-cycle round-complete pulse.
REQ-010 SHALL have port round_result  output  2  00 tie, 01 P1 wins, 10 P2 wins, 11 reserved/never driven.
REQ-011 SHALL have ports score1 / score2  output  3  round-win counts.
REQ-012 SHALL have port match_over  output  1  level, high while in OVER.
REQ-013 SHALL have port winner  output  2  00 draw, 01 P1, 10 P2; valid while match_over.

Function
REQ-014 SHALL implement states IDLE, COLLECT, JUDGE, REPORT, OVER.
REQ-015 IDLE: start=1 -> COLLECT next cycle; scores cleared to 0, lock flags cleared, armed cleared.
REQ-016 timer_go SHALL be 0 in IDLE and 1 in COLLECT, JUDGE, REPORT and OVER.
REQ-017 armed flag SHALL set on the first cycle timer_expired=0 while timer_go=1; timer_expired SHALL be ignored while armed=0.
REQ-018 Time-up SHALL mean armed=1 and timer_expired=1.
REQ-019 COLLECT: per player, the first cycle with valid=1 and move!=11 SHALL latch the move and set that player's lock.
REQ-020 Further strobes for a locked player, and illegal moves, SHALL be ignored until the next round.
REQ-021 Both players MAY lock in the same cycle.
REQ-022 COLLECT -> JUDGE on the cycle after both locks are set.
REQ-023 JUDGE SHALL take exactly one cycle.
REQ-024 JUDGE SHALL register round_result: equal moves -> 00; rock>scissors, scissors>paper, paper>rock.
REQ-025 JUDGE SHALL increment the winner's score (tie: no change) and then move to REPORT.
REQ-026 REPORT SHALL assert round_done for exactly one cycle and clear both locks.
REQ-027 REPORT SHALL go to OVER if either score equals WIN_SCORE or time-up is true; otherwise back to COLLECT.
REQ-028 Time-up in COLLECT SHALL go directly to OVER; partial locks are discarded and no round is scored.
REQ-029 Time-up during JUDGE SHALL be deferred: the round is scored and reported, and REPORT then goes to OVER.
REQ-030 winner SHALL be registered on entry to OVER: higher score wins; equal scores -> 00.
REQ-031 OVER SHALL be held until reset; start SHALL be ignored in every state except IDLE.
REQ-032 Scores SHALL saturate at WIN_SCORE, never wrap.
REQ-033 round_result, scores and winner SHALL hold their value between updates.
REQ-034 Latency: last lock edge -> JUDGE +1 cycle -> round_done +2 cycles.

Reset
REQ-035 reset=1 SHALL override all inputs in the same edge, including start and move strobes.
REQ-036 Reset values: state IDLE; timer_go 0; round_done 0; round_result 00; score1/score2 0; match_over 0; winner 00; locks 0; armed 0.
REQ-037 Reset asserted mid-round or in OVER SHALL return to IDLE on the next edge, with all outputs at reset values.

Verification
REQ-038 Win path: start; P1 rock, P2 scissors in the same cycle; repeat 3 rounds -> round_done 3 pulses, result 01 each, score1=3, match_over=1, winner=01.
REQ-039 Tie and illegal moves: P1 11 then paper, P2 paper -> the 11 is ignored; result 00, scores unchanged, back to COLLECT.
REQ-040 Relock ignored: P1 rock, then P1 paper before P2 locks; P2 scissors -> result 01.
REQ-041 Timeout: timer_expired held 1 at start, drops to 0, later returns to 1 with only P1 locked -> OVER without round_done; with score1=1, score2=1 -> winner=00.
REQ-042 Timeout in JUDGE: time-up in the JUDGE cycle -> round scored, round_done pulses, then OVER.
REQ-043 Reset in REPORT: outputs return to reset values next cycle; start in OVER has no effect.
